// File: rtl/count_seq_ctrl_pkg.sv
// Shared divider constants and FSM state encoding for the display counter sequencer.
package count_seq_ctrl_pkg;

    localparam int F_1HZ   = 50_000_000;
    localparam int F_10HZ  = 5_000_000;
    localparam int F_100HZ = 500_000;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Divider register width; a 2-cycle divider still needs one bit.
    function automatic int div_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Front-panel controls in, display bus and status out.
interface count_seq_ctrl_if #(
    parameter int W = count_seq_ctrl_pkg::CNT_W
);
    logic         start;
    logic         stop;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic         up_dn;
    logic         oneshot;
    logic [W-1:0] data;
    logic         running;
    logic         done;
    logic         tick;

    modport master (
        output start, stop, clear, load, load_val, limit, up_dn, oneshot,
        input  data, running, done, tick
    );

    modport slave (
        input  start, stop, clear, load, load_val, limit, up_dn, oneshot,
        output data, running, done, tick
    );
endinterface

// File: rtl/count_seq_ctrl_tick_gen.sv
// Enable-style divider: one-cycle tick every M enabled cycles, no derived clock.
module tick_gen
    import count_seq_ctrl_pkg::*;
#(
    parameter int M = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int            DW   = div_width(M);
    localparam logic [DW-1:0] LAST = DW'(M - 1);

    logic [DW-1:0] cnt;

    // Count freezes while disabled so a paused period resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/count_seq_ctrl.sv
// Run/pause/clear sequencer for the display counter: FSM plus counter, single clock.
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int M = F_1HZ,
    parameter int W = CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    count_seq_ctrl_if.slave bus
);
    state_e       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] step_val;
    logic         step_term;
    logic         tick;
    logic         div_clr;
    logic         in_run;
    logic         end_here;

    assign in_run = (state_q == ST_RUN);

    tick_gen #(.M(M)) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (in_run),
        .sync_clr (div_clr),
        .tick     (tick)
    );

    // Value the counter takes if a tick lands this cycle; step_term marks the terminal value.
    always_comb begin
        step_term = 1'b0;
        step_val  = data_q;
        if (bus.up_dn) begin
            step_term = (data_q == bus.limit);
            step_val  = step_term ? '0 : data_q + 1'b1;
        end else begin
            step_term = (data_q == '0);
            step_val  = step_term ? bus.limit : data_q - 1'b1;
        end
    end

    assign end_here = tick && step_term && bus.oneshot;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        div_clr = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            data_d  = '0;
            div_clr = 1'b1;
        end else begin
            unique case (state_q)
                // load is not a command in RUN, so stop still applies alongside it.
                ST_RUN: begin
                    if (end_here) begin
                        state_d = ST_DONE;
                    end else begin
                        if (tick) data_d = step_val;
                        if (bus.stop) state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.load) begin
                        data_d = bus.load_val;
                    end else if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (bus.load) begin
                        data_d  = bus.load_val;
                        state_d = ST_IDLE;
                    end else if (bus.start) begin
                        state_d = ST_RUN;
                        div_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign bus.data    = data_q;
    assign bus.running = in_run;
    assign bus.done    = (state_q == ST_DONE);
    assign bus.tick    = tick;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench: driver predicts each cycle from a behavioural model, monitor compares.
module tb_count_seq_ctrl;
    localparam int M = 4;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    count_seq_ctrl_if #(.W(W)) bus ();

    count_seq_ctrl #(.M(M), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit start;
        bit stop;
        bit clear;
        bit load;
        bit up_dn;
        bit oneshot;
        int load_val;
        int limit;
    } cmd_t;

    typedef struct {
        int data;
        bit running;
        bit done;
        bit tick;
    } exp_t;

    exp_t  q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    cmd_t  base;

    // Reference model: mode name, displayed value, cycles elapsed in current tick period.
    string m_mode  = "idle";
    int    m_data  = 0;
    int    m_phase = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input cmd_t c);
        bit fire;
        bit at_end;
        fire = (m_mode == "run") && (m_phase == M - 1);
        if (c.clear) begin
            m_mode  = "idle";
            m_data  = 0;
            m_phase = 0;
        end else if (m_mode == "run") begin
            m_phase = (m_phase + 1) % M;
            at_end  = c.up_dn ? (m_data == c.limit) : (m_data == 0);
            if (fire && at_end && c.oneshot) begin
                m_mode = "done";
            end else begin
                if (fire) begin
                    if (c.up_dn) m_data = at_end ? 0 : (m_data + 1) % (1 << W);
                    else         m_data = at_end ? c.limit : m_data - 1;
                end
                if (c.stop) m_mode = "pause";
            end
        end else if (c.load) begin
            m_data = c.load_val;
            if (m_mode == "done") m_mode = "idle";
        end else if (c.start) begin
            if (m_mode != "pause") m_phase = 0;
            m_mode = "run";
        end
    endtask

    task automatic cyc(input cmd_t c);
        exp_t e;
        @(negedge clk);
        bus.start    = c.start;
        bus.stop     = c.stop;
        bus.clear    = c.clear;
        bus.load     = c.load;
        bus.load_val = W'(c.load_val);
        bus.limit    = W'(c.limit);
        bus.up_dn    = c.up_dn;
        bus.oneshot  = c.oneshot;
        model_step(c);
        e.data    = m_data;
        e.running = (m_mode == "run");
        e.done    = (m_mode == "done");
        e.tick    = e.running && (m_phase == M - 1);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(base);
    endtask

    task automatic cmd(input bit st, input bit sp, input bit cl, input bit ld, input int lv);
        cmd_t c;
        c = base;
        c.start = st; c.stop = sp; c.clear = cl; c.load = ld; c.load_val = lv;
        cyc(c);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_data"},    int'(bus.data), 0);
        chk({tag, "_status"},  int'({bus.running, bus.done, bus.tick}), 0);
        m_mode = "idle"; m_data = 0; m_phase = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every clock with reset released and a prediction pending, compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("data",    int'(bus.data),    e.data);
                chk("running", int'(bus.running), int'(e.running));
                chk("done",    int'(bus.done),    int'(e.done));
                chk("tick",    int'(bus.tick),    int'(e.tick));
            end
        end
    end

    initial begin
        cmd_t c;
        int   r;
        base = '{start: 0, stop: 0, clear: 0, load: 0, up_dn: 1, oneshot: 0,
                 load_val: 0, limit: 3};
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
        bus.load_val = '0; bus.limit = '0; bus.up_dn = 1'b1; bus.oneshot = 1'b0;

        reset_check("por");

        // Up, wrapping at limit 3.
        cmd(1, 0, 0, 0, 0);
        idle(22);

        // Oneshot at limit 2, then restart in wrap mode.
        cmd(0, 0, 1, 0, 0);
        base.limit = 2; base.oneshot = 1;
        cmd(1, 0, 0, 0, 0);
        idle(16);
        base.oneshot = 0;
        cmd(1, 0, 0, 0, 0);
        idle(8);

        // Down from loaded 1, reload at 5, pause mid-period and resume.
        cmd(0, 0, 1, 0, 0);
        base.up_dn = 0; base.limit = 5;
        cmd(0, 0, 0, 1, 1);
        cmd(1, 0, 0, 0, 0);
        idle(9);
        cmd(0, 1, 0, 0, 0);
        idle(10);
        cmd(1, 0, 0, 0, 0);
        idle(12);

        // clear beats load and start while paused at 7.
        cmd(0, 0, 1, 0, 0);
        base.up_dn = 1; base.limit = 20;
        cmd(0, 0, 0, 1, 7);
        cmd(1, 0, 0, 0, 0);
        cmd(0, 1, 0, 0, 0);
        idle(3);
        cmd(1, 0, 1, 1, 9);
        idle(6);

        // load ignored in RUN, stop landing on a tick cycle, start&stop together.
        cmd(1, 0, 0, 0, 0);
        cmd(0, 0, 0, 1, 99);
        for (int i = 0; i < 2 * M && !(m_mode == "run" && m_phase == M - 1); i++) idle(1);
        cmd(0, 1, 0, 0, 0);
        idle(3);
        cmd(1, 0, 0, 0, 0);
        cmd(1, 1, 0, 0, 0);
        idle(3);

        // Loaded above limit in up mode: wraps through all-ones, then terminates at limit.
        cmd(0, 0, 1, 0, 0);
        base.limit = 1; base.oneshot = 1;
        cmd(0, 0, 0, 1, 254);
        cmd(1, 0, 0, 0, 0);
        idle(18);

        // Async reset mid-RUN with data at 5.
        cmd(0, 0, 1, 0, 0);
        base.limit = 200; base.oneshot = 0;
        cmd(0, 0, 0, 1, 5);
        cmd(1, 0, 0, 0, 0);
        idle(2);
        reset_check("mid_run");
        idle(2);

        // Randomized commands and settings.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                base.limit   = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 9);
                base.up_dn   = 1'($urandom_range(0, 1));
                base.oneshot = ($urandom_range(0, 3) == 0);
            end
            c = base;
            r = $urandom_range(0, 99);
            c.clear    = (r < 2);
            c.load     = (r >= 2 && r < 8);
            c.stop     = (r >= 8 && r < 14) || ($urandom_range(0, 31) == 0);
            c.start    = (r >= 14 && r < 26) || ($urandom_range(0, 31) == 0);
            c.load_val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            cyc(c);
        end
        idle(2);

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
